// File: rtl/addsub_serial_nbits.sv
//------------------------------------------------------------------------------
// addsub_serial_nbits : chunk-serial WIDTH-bit adder/subtractor, CHUNK bits/clk
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_serial_nbits #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Sub,
  output logic             Cout,
  output logic             Signal,
  output logic             Zero,
  output logic             Overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  int               chunk_lo;
  logic [CHUNK-1:0] a_k, b_k, b_eff;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_full;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    carry_d  = carry_q;
    k_d      = k_q;
    sub_d    = sub_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    chunk_lo = int'(k_q) * CHUNK;
    a_k      = a_q[chunk_lo +: CHUNK];
    b_k      = b_q[chunk_lo +: CHUNK];
    // Subtraction runs as A + ~B with the borrow-in inverted into the carry.
    b_eff    = op_q ? ~b_k : b_k;
    sum      = {1'b0, a_k} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
    res_full = acc_q;
    res_full[chunk_lo +: CHUNK] = sum[CHUNK-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = Op;
          carry_d = Op ? ~Cin : Cin;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = res_full;
        carry_d = sum[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          sub_d   = res_full;
          cout_d  = op_q ^ sum[CHUNK];
          zero_d  = (res_full == '0);
          ovf_d   = ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) == op_q) &&
                    (res_full[WIDTH-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sub_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign Sub      = sub_q;
  assign Cout     = cout_q;
  assign Signal   = sub_q[WIDTH-1];
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_serial_nbits.sv
//------------------------------------------------------------------------------
// tb_addsub_serial_nbits : directed and swept checks of the serial add/sub
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_addsub_serial_nbits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  // index 0: 32/8 (N=4), 1: 32/1 (N=32), 2: 32/4 (N=8), 3: 32/32 (N=1)
  logic [3:0]  rdy, dn, co, sg, zr, ov;
  logic [31:0] sb [4];
  logic        n_rdy, n_dn, n_co, n_sg, n_zr, n_ov;
  logic [7:0]  n_sub;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_serial_nbits #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(op), .A(a), .B(b), .Cin(cin),
    .ready(rdy[0]), .done(dn[0]), .Sub(sb[0]), .Cout(co[0]), .Signal(sg[0]),
    .Zero(zr[0]), .Overflow(ov[0]));

  addsub_serial_nbits #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(op), .A(a), .B(b), .Cin(cin),
    .ready(rdy[1]), .done(dn[1]), .Sub(sb[1]), .Cout(co[1]), .Signal(sg[1]),
    .Zero(zr[1]), .Overflow(ov[1]));

  addsub_serial_nbits #(.WIDTH(32), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(op), .A(a), .B(b), .Cin(cin),
    .ready(rdy[2]), .done(dn[2]), .Sub(sb[2]), .Cout(co[2]), .Signal(sg[2]),
    .Zero(zr[2]), .Overflow(ov[2]));

  addsub_serial_nbits #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(op), .A(a), .B(b), .Cin(cin),
    .ready(rdy[3]), .done(dn[3]), .Sub(sb[3]), .Cout(co[3]), .Signal(sg[3]),
    .Zero(zr[3]), .Overflow(ov[3]));

  addsub_serial_nbits #(.WIDTH(8), .CHUNK(2)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(op), .A(a[7:0]), .B(b[7:0]),
    .Cin(cin), .ready(n_rdy), .done(n_dn), .Sub(n_sub), .Cout(n_co),
    .Signal(n_sg), .Zero(n_zr), .Overflow(n_ov));

  // Reference: returns {overflow, cout, result} for an arbitrary width w <= 32.
  function automatic logic [33:0] model(input int w, input logic o,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    longint m, ux, uy, sx, sy, full, sr, cc;
    logic   co_, ov_;
    m  = (longint'(1) << w) - 1;
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    cc = longint'(c);
    sx = (((ux >> (w - 1)) & 1) != 0) ? ux - (m + 1) : ux;
    sy = (((uy >> (w - 1)) & 1) != 0) ? uy - (m + 1) : uy;
    if (o) begin
      full = ux - uy - cc;
      co_  = (ux < uy + cc);
      sr   = sx - sy - cc;
    end else begin
      full = ux + uy + cc;
      co_  = ((full >> w) & 1) != 0;
      sr   = sx + sy + cc;
    end
    ov_ = (sr > (m >> 1)) || (sr < -((m >> 1) + 1));
    return {ov_, co_, 32'(full & m)};
  endfunction

  // Launch one operation on the shared inputs; lat counts edges from the
  // sampling edge (1) to the edge after which done is seen on the 32/8 unit.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic c, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    lat = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dn[0]) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0], rdy[0], dn[0]} !== {32'h0, 6'b000010}) begin
      errors++;
      $display("FAIL reset: got sub=%h co=%b sg=%b zr=%b ov=%b rdy=%b dn=%b, want 0/0/0/0/0/1/0",
               sb[0], co[0], sg[0], zr[0], ov[0], rdy[0], dn[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sub;
    int lat;
    do_op(1'b1, 32'd5, 32'd3, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL sub_latency: got %0d want 5", lat);
    end
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'd2, 4'b0000}) begin
      errors++; $display("FAIL sub_5_3: got %h %b%b%b%b want 2 0000", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
    do_op(1'b1, 32'd10, 32'd3, 1'b1, lat);
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'd6, 4'b0000}) begin
      errors++; $display("FAIL sub_10_3_b1: got %h %b%b%b%b want 6 0000", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
    do_op(1'b1, 32'd3, 32'd5, 1'b0, lat);
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'hFFFF_FFFE, 4'b1100}) begin
      errors++; $display("FAIL sub_3_5: got %h %b%b%b%b want fffffffe 1100", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
    do_op(1'b1, 32'h8000_0000, 32'd1, 1'b0, lat);
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'h7FFF_FFFF, 4'b0001}) begin
      errors++; $display("FAIL sub_min_1: got %h %b%b%b%b want 7fffffff 0001", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
  endtask

  task automatic test_add;
    int lat;
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'h0, 4'b1010}) begin
      errors++; $display("FAIL add_wrap: got %h %b%b%b%b want 0 1010", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
    do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'h8000_0000, 4'b0101}) begin
      errors++; $display("FAIL add_ovf: got %h %b%b%b%b want 80000000 0101", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
    do_op(1'b0, 32'h0000_00FF, 32'd1, 1'b0, lat);
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0]} !== {32'h0000_0100, 4'b0000}) begin
      errors++; $display("FAIL add_chunk_cross: got %h %b%b%b%b want 100 0000", sb[0], co[0], sg[0], zr[0], ov[0]);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    op = 1'b1; a = 32'd5; b = 32'd3; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    op = 1'b0; a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int e = 3; e <= 50; e++) begin
      @(posedge clk); #1;
      if (dn[0]) begin
        lat = e;
        break;
      end
    end
    checks++;
    if (lat !== 5 || sb[0] !== 32'd2) begin
      errors++; $display("FAIL ignore_start: got lat=%0d sub=%h want lat=5 sub=2", lat, sb[0]);
    end
  endtask

  task automatic test_back_to_back;
    int lat, unstable;
    do_op(1'b0, 32'd1, 32'd2, 1'b0, lat);
    checks++;
    if (rdy[0] !== 1'b1 || dn[0] !== 1'b1 || sb[0] !== 32'd3) begin
      errors++; $display("FAIL b2b_first: got rdy=%b dn=%b sub=%h want 1 1 3", rdy[0], dn[0], sb[0]);
    end
    op = 1'b1; a = 32'd9; b = 32'd4; cin = 1'b0; start = 1'b1;
    lat = 0; unstable = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dn[0]) begin
        lat = e;
        break;
      end
      if (sb[0] !== 32'd3) unstable++;
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL b2b_latency: got %0d want 5", lat);
    end
    checks++;
    if (unstable !== 0) begin
      errors++; $display("FAIL b2b_hold: got %0d cycles with changed sub, want 0", unstable);
    end
    checks++;
    if (sb[0] !== 32'd5) begin
      errors++; $display("FAIL b2b_second: got %h want 5", sb[0]);
    end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    @(negedge clk);
    op = 1'b1; a = 32'd7; b = 32'd1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sb[0], co[0], sg[0], zr[0], ov[0], rdy[0], dn[0]} !== {32'h0, 6'b000010}) begin
      errors++; $display("FAIL reset_mid_run: got sub=%h rdy=%b dn=%b want 0 1 0", sb[0], rdy[0], dn[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (dn[0]) pulses++;
    end
    checks++;
    if (pulses !== 0 || sb[0] !== 32'h0) begin
      errors++; $display("FAIL abort_no_done: got %0d pulses sub=%h want 0 0", pulses, sb[0]);
    end
  endtask

  task automatic test_sweep;
    int          nl [5];
    int          lat [5];
    logic [33:0] e32, e8;
    nl = '{4, 32, 8, 1, 4};
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 1'($urandom); cin = 1'($urandom);
      if (v == 0) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; op = 1'b0; cin = 1'b1; end
      if (v == 1) begin a = 32'h8000_0000; b = 32'h0000_0000; op = 1'b1; cin = 1'b1; end
      start = 1'b1;
      lat = '{0, 0, 0, 0, 0};
      for (int e = 1; e <= 40; e++) begin
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) if (dn[i] && lat[i] == 0) lat[i] = e;
        if (n_dn && lat[4] == 0) lat[4] = e;
      end
      e32 = model(32, op, a, b, cin);
      e8  = model(8, op, a, b, cin);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({ov[i], co[i], sb[i]} !== e32 || lat[i] !== nl[i] + 1) begin
          errors++;
          $display("FAIL sweep32_%0d vec%0d: got ov=%b co=%b sub=%h lat=%0d want ov=%b co=%b sub=%h lat=%0d",
                   i, v, ov[i], co[i], sb[i], lat[i], e32[33], e32[32], e32[31:0], nl[i] + 1);
        end
      end
      checks++;
      if ({n_ov, n_co, n_sub} !== {e8[33:32], e8[7:0]} || lat[4] !== nl[4] + 1) begin
        errors++;
        $display("FAIL sweep8 vec%0d: got ov=%b co=%b sub=%h lat=%0d want ov=%b co=%b sub=%h lat=%0d",
                 v, n_ov, n_co, n_sub, lat[4], e8[33], e8[32], e8[7:0], nl[4] + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
